// File: rtl/jtopl_wrbuf.sv
// CPU write buffer in front of the OPL register map.
// Queues CPU port writes and replays them with chip recovery gaps.
module jtopl_wrbuf #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          cpu_wr,
    input  logic          cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          ovf_clr,
    output logic          mmr_write,
    output logic          mmr_addr,
    output logic [7:0]    mmr_din,
    output logic          busy,
    output logic          full,
    output logic          ovf,
    output logic [AW:0]   level
);

    localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int CW   = $clog2(MAXW + 2);

    localparam logic [AW-1:0] PONE  = 1;
    localparam logic [AW:0]   LONE  = 1;
    localparam logic [AW:0]   LFULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CONE  = 1;
    localparam logic [CW-1:0] AWAIT = CW'(ADDR_WAIT);
    localparam logic [CW-1:0] DWAIT = CW'(DATA_WAIT);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          ovf_q, ovf_d;

    logic          full_w;
    logic          pop;
    logic          push;
    logic          drop;
    logic [8:0]    head;
    logic [CW-1:0] load;

    always_comb begin
        full_w = (level_q == LFULL);
        head   = mem_q[rptr_q];
        // No pop while a strobe is out: keeps issues one clk apart.
        pop    = (state_q == IDLE) && (level_q != '0) && !wr_q;
        // A pop frees a slot in the same cycle, so a full FIFO can accept.
        push   = cpu_wr && (!full_w || pop);
        drop   = cpu_wr && !push;
        load   = head[8] ? DWAIT : AWAIT;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        ovf_d   = ovf_q;

        if (state_q == WAIT && cen) begin
            cnt_d = cnt_q - CONE;
            if (cnt_q == CONE) begin
                state_d = IDLE;
            end
        end

        if (pop) begin
            rptr_d  = rptr_q + PONE;
            wr_d    = 1'b1;
            addr_d  = head[8];
            din_d   = head[7:0];
            cnt_d   = load;
            state_d = (load != '0) ? WAIT : IDLE;
        end

        if (push) begin
            wptr_d = wptr_q + PONE;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LONE;
            2'b01:   level_d = level_q - LONE;
            default: level_d = level_q;
        endcase

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 1'b0;
            din_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wptr_q] <= {cpu_addr, cpu_din};
        end
    end

    assign mmr_write = wr_q;
    assign mmr_addr  = addr_q;
    assign mmr_din   = din_q;
    assign full      = full_w;
    assign ovf       = ovf_q;
    assign level     = level_q;
    assign busy      = (level_q != '0) || (state_q != IDLE) || wr_q;

endmodule

// File: tb/tb_jtopl_wrbuf.sv
// Directed bench for jtopl_wrbuf with scoreboarded issue checks.
// A second instance runs with zero recovery waits.
module tb_jtopl_wrbuf;

    logic       clk;
    logic       rst;
    logic       cen;
    logic       cpu_wr;
    logic       cpu_addr;
    logic [7:0] cpu_din;
    logic       ovf_clr;
    logic       m_write, m_addr, m_busy, m_full, m_ovf;
    logic [7:0] m_din;
    logic [3:0] m_level;

    logic       z_wr, z_addr;
    logic [7:0] z_din;
    logic       z_write, z_maddr, z_busy, z_full, z_ovf;
    logic [7:0] z_mdin;
    logic [3:0] z_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_main = 0;
    int cen_mode = 0;
    logic cen_man = 1'b0;
    logic [8:0] sbq[$];
    logic [8:0] zq[$];
    int z_cycles[$];
    logic m_prev = 1'b0;
    logic z_prev = 1'b0;

    jtopl_wrbuf dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .ovf_clr(ovf_clr),
        .mmr_write(m_write), .mmr_addr(m_addr), .mmr_din(m_din),
        .busy(m_busy), .full(m_full), .ovf(m_ovf), .level(m_level)
    );

    jtopl_wrbuf #(.ADDR_WAIT(0), .DATA_WAIT(0)) dut_z (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_wr(z_wr), .cpu_addr(z_addr), .cpu_din(z_din),
        .ovf_clr(ovf_clr),
        .mmr_write(z_write), .mmr_addr(z_maddr), .mmr_din(z_mdin),
        .busy(z_busy), .full(z_full), .ovf(z_ovf), .level(z_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // cen: tied high, every 4th clk, or driven by the sequence.
    initial begin
        int n;
        n = 0;
        cen = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            n++;
            case (cen_mode)
                0:       cen = 1'b1;
                1:       cen = (n % 4 == 0);
                default: cen = cen_man;
            endcase
        end
    end

    initial begin
        #2000000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_write) begin
            n_main++;
            chk("main_adjacent", 32'(m_prev), 32'd0);
            if (sbq.size() == 0) begin
                chk("main_unexpected", 32'd1, 32'd0);
            end else begin
                chk("main_issue", 32'({m_addr, m_din}),
                    32'(sbq.pop_front()));
            end
        end
        if (z_write) begin
            z_cycles.push_back(cyc);
            chk("z_adjacent", 32'(z_prev), 32'd0);
            if (zq.size() == 0) begin
                chk("z_unexpected", 32'd1, 32'd0);
            end else begin
                chk("z_issue", 32'({z_maddr, z_mdin}), 32'(zq.pop_front()));
            end
        end
        m_prev <= m_write;
        z_prev <= z_write;
    end

    task automatic wr(input logic a, input logic [7:0] d);
        cpu_wr = 1'b1;
        cpu_addr = a;
        cpu_din = d;
        @(posedge clk);
        #1;
        cpu_wr = 1'b0;
    endtask

    // Counts cen-high edges until the next strobe or until busy drops.
    task automatic ticks_until(input bit to_write, output int t,
                               output logic lastc);
        logic c;
        bit done;
        t = 0;
        lastc = 1'b0;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            c = cen;
            @(negedge clk);
            if (to_write && m_write) begin
                done = 1;
            end else begin
                if (c) t++;
                lastc = c;
                if (!to_write && !m_busy) done = 1;
            end
        end
        if (!done) chk("ticks_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_write;
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_write;
        end
        chk("first_pulse_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int t;
        logic lc;
        int n0;
        bit idle;
        rst = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = 1'b0;
        cpu_din = 8'h00;
        ovf_clr = 1'b0;
        z_wr = 1'b0;
        z_addr = 1'b0;
        z_din = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_write", 32'(m_write), 32'd0);
        chk("rst_addr", 32'(m_addr), 32'd0);
        chk("rst_din", 32'(m_din), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_full", 32'(m_full), 32'd0);
        chk("rst_ovf", 32'(m_ovf), 32'd0);
        chk("rst_level", 32'(m_level), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single address write, cen tied high
        sbq.push_back({1'b0, 8'hBD});
        wr(1'b0, 8'hBD);
        @(negedge clk);
        chk("t1_level", 32'(m_level), 32'd1);
        chk("t1_busy", 32'(m_busy), 32'd1);
        chk("t1_nowrite_yet", 32'(m_write), 32'd0);
        @(negedge clk);
        chk("t1_write", 32'(m_write), 32'd1);
        ticks_until(0, t, lc);
        chk("t1_busy_ticks", 32'(t), 32'd12);
        chk("t1_busy_lastcen", 32'(lc), 32'd1);
        chk("t1_hold_din", 32'(m_din), 32'hBD);
        chk("t1_hold_addr", 32'(m_addr), 32'd0);

        // Address then data, cen every 4 clks
        @(posedge clk);
        #1;
        cen_mode = 1;
        repeat (8) @(posedge clk);
        #1;
        sbq.push_back({1'b0, 8'h20});
        sbq.push_back({1'b1, 8'h01});
        wr(1'b0, 8'h20);
        wr(1'b1, 8'h01);
        wait_write();
        ticks_until(1, t, lc);
        chk("t2_gap_ticks", 32'(t), 32'd12);
        chk("t2_gap_lastcen", 32'(lc), 32'd1);
        ticks_until(0, t, lc);
        chk("t2_busy_ticks", 32'(t), 32'd84);
        chk("t2_busy_lastcen", 32'(lc), 32'd1);

        // Overflow burst while waiting, then push on the pop edge
        @(posedge clk);
        #1;
        cen_man = 1'b0;
        cen_mode = 2;
        @(posedge clk);
        #1;
        sbq.push_back({1'b1, 8'hA0});
        wr(1'b1, 8'hA0);
        @(posedge clk);
        #1;
        cpu_wr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cpu_addr = i[0];
            cpu_din = 8'h30 + 8'(i);
            if (i < 8) sbq.push_back({cpu_addr, cpu_din});
            @(posedge clk);
            #1;
        end
        cpu_wr = 1'b0;
        @(negedge clk);
        chk("t3_level", 32'(m_level), 32'd8);
        chk("t3_full", 32'(m_full), 32'd1);
        chk("t3_ovf", 32'(m_ovf), 32'd1);
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("t3_ovf_clr", 32'(m_ovf), 32'd0);
        chk("t3_level_kept", 32'(m_level), 32'd8);
        @(posedge clk);
        #1;
        cen_man = 1'b1;
        repeat (84) @(posedge clk);
        #1;
        cen_man = 1'b0;
        cpu_wr = 1'b1;
        cpu_addr = 1'b0;
        cpu_din = 8'hEE;
        sbq.push_back({1'b0, 8'hEE});
        @(posedge clk);
        #1;
        cpu_wr = 1'b0;
        @(negedge clk);
        chk("t4_popwrite", 32'(m_write), 32'd1);
        chk("t4_level", 32'(m_level), 32'd8);
        chk("t4_full", 32'(m_full), 32'd1);
        chk("t4_ovf", 32'(m_ovf), 32'd0);
        cen_mode = 0;
        idle = 0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            idle = !m_busy;
        end
        chk("t4_drained", 32'(idle), 32'd1);
        chk("t4_sb_empty", 32'(sbq.size()), 32'd0);

        // Zero-wait instance: four queued writes
        @(posedge clk);
        #1;
        z_cycles.delete();
        z_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            z_addr = ~i[0];
            z_din = 8'hC0 + 8'(i);
            zq.push_back({z_addr, z_din});
            @(posedge clk);
            #1;
        end
        z_wr = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_count", 32'(z_cycles.size()), 32'd4);
        if (z_cycles.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("t5_spacing", 32'(z_cycles[i] - z_cycles[i-1]), 32'd2);
            end
        end
        chk("t5_zq_empty", 32'(zq.size()), 32'd0);

        // Reset with five entries queued during a wait
        @(posedge clk);
        #1;
        cpu_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_addr = 1'b1;
            cpu_din = 8'h50 + 8'(i);
            sbq.push_back({cpu_addr, cpu_din});
            @(posedge clk);
            #1;
        end
        cpu_wr = 1'b0;
        @(negedge clk);
        chk("t6_level_pre", 32'(m_level), 32'd5);
        chk("t6_busy_pre", 32'(m_busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_level", 32'(m_level), 32'd0);
        chk("t6_busy", 32'(m_busy), 32'd0);
        chk("t6_write", 32'(m_write), 32'd0);
        chk("t6_full", 32'(m_full), 32'd0);
        n0 = n_main;
        repeat (200) @(negedge clk);
        chk("t6_no_issue", 32'(n_main), 32'(n0));
        chk("t6_still_idle", 32'(m_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
